// File: rtl/keccak_pad_blk.sv
// keccak_pad_blk: packs a byte stream into little-endian 64-bit lanes, applies
// Keccak pad10*1 with a domain-separation byte, and emits 25-lane state frames.
module keccak_pad_blk #(
    parameter int unsigned RATE_LANES = 17,
    parameter logic [7:0]  DSBYTE     = 8'h06
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pushin,
    output logic        stopin,
    input  logic        lastin,
    input  logic [7:0]  din,
    output logic        pushout,
    input  logic        stopout,
    output logic        firstout,
    output logic [63:0] dout
);

    localparam int unsigned LANE_W    = 64;
    localparam logic [4:0]  LAST_RATE = 5'(RATE_LANES - 1);
    localparam logic [4:0]  LAST_LANE = 5'd24;
    localparam logic [LANE_W-1:0] PAD_TOP = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {
        ABSORB = 2'd0,
        PAD    = 2'd1,
        CAP    = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        bc;
    logic [4:0]        ln;
    logic [LANE_W-1:0] lane_asm;
    logic              pad_pending;

    logic              out_adv;
    logic              accept;
    logic              last_rate;
    logic [5:0]        ds_shift;
    logic [LANE_W-1:0] asm_wr;
    logic [LANE_W-1:0] ds_mask;

    // Input backpressure: only absorb while the output register can take a lane.
    assign stopin    = rst || (state != ABSORB) || (pushout && stopout);
    assign out_adv   = !pushout || !stopout;
    assign accept    = pushin && !stopin;
    assign last_rate = (ln == LAST_RATE);
    assign ds_shift  = 6'({bc, 3'b000}) + 6'd8;
    assign ds_mask   = LANE_W'(DSBYTE) << ds_shift;

    // Assembly register with the incoming byte merged at position bc.
    always_comb begin
        asm_wr = lane_asm;
        asm_wr[8*bc +: 8] = din;
    end

    // Frame sequencer: absorb, pad and capacity phases with registered output lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ABSORB;
            bc          <= 3'd0;
            ln          <= 5'd0;
            lane_asm    <= '0;
            pad_pending <= 1'b0;
            pushout     <= 1'b0;
            firstout    <= 1'b0;
            dout        <= '0;
        end else begin
            case (state)
                ABSORB: begin
                    if (accept && bc == 3'd7) begin
                        pushout  <= 1'b1;
                        dout     <= asm_wr;
                        firstout <= (ln == 5'd0);
                        ln       <= ln + 5'd1;
                        bc       <= 3'd0;
                        if (last_rate) begin
                            lane_asm    <= '0;
                            pad_pending <= lastin;
                            state       <= CAP;
                        end else if (lastin) begin
                            // DSBYTE wraps into byte 0 of the next lane
                            lane_asm <= LANE_W'(DSBYTE);
                            state    <= PAD;
                        end else begin
                            lane_asm <= '0;
                        end
                    end else begin
                        if (accept) begin
                            bc <= bc + 3'd1;
                            if (lastin) begin
                                lane_asm <= asm_wr | ds_mask;
                                state    <= PAD;
                            end else begin
                                lane_asm <= asm_wr;
                            end
                        end
                        if (out_adv) begin
                            pushout <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    if (out_adv) begin
                        pushout  <= 1'b1;
                        dout     <= last_rate ? (lane_asm | PAD_TOP) : lane_asm;
                        firstout <= (ln == 5'd0);
                        lane_asm <= '0;
                        ln       <= ln + 5'd1;
                        if (last_rate) begin
                            pad_pending <= 1'b0;
                            state       <= CAP;
                        end
                    end
                end
                CAP: begin
                    if (out_adv) begin
                        pushout  <= 1'b1;
                        dout     <= '0;
                        firstout <= (ln == 5'd0);
                        if (ln == LAST_LANE) begin
                            ln <= 5'd0;
                            bc <= 3'd0;
                            // A full final block leaves a padding-only frame to send
                            lane_asm <= pad_pending ? LANE_W'(DSBYTE) : '0;
                            state    <= pad_pending ? PAD : ABSORB;
                        end else begin
                            ln <= ln + 5'd1;
                        end
                    end
                end
                default: state <= ABSORB;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_pad_blk.sv
// Directed bench for keccak_pad_blk: frame contents, stall, reset abort, back-to-back.
module tb_keccak_pad_blk;

    logic        clk = 1'b0;
    logic        rst;
    logic        pushin;
    logic        stopin;
    logic        lastin;
    logic [7:0]  din;
    logic        pushout;
    logic        stopout;
    logic        firstout;
    logic [63:0] dout;

    int checks = 0;
    int errors = 0;

    logic [63:0] q_dout[$];
    bit          q_first[$];

    keccak_pad_blk #(.RATE_LANES(17), .DSBYTE(8'h06)) dut (
        .clk(clk), .rst(rst), .pushin(pushin), .stopin(stopin), .lastin(lastin),
        .din(din), .pushout(pushout), .stopout(stopout), .firstout(firstout), .dout(dout)
    );

    always #5 clk = ~clk;

    // Record every lane that transfers on the coming rising edge.
    always @(negedge clk) begin
        if (pushout === 1'b1 && stopout === 1'b0) begin
            q_dout.push_back(dout);
            q_first.push_back(firstout);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        bit ok = 1'b0;
        pushin = 1'b1;
        din    = b;
        lastin = last;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk);
            if (!stopin) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            chk("send_timeout", 64'(ok), 64'd1);
        end
    endtask

    task automatic idle();
        pushin = 1'b0;
        lastin = 1'b0;
    endtask

    task automatic send_abc();
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
    endtask

    task automatic wait_lanes(input string tag, input int n);
        for (int k = 0; k < 3000 && q_dout.size() < n; k++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_count"}, 64'(q_dout.size()), 64'(n));
    endtask

    // Lane 0, lanes 1..15 and lane 16 given; capacity lanes 17..24 must be zero.
    task automatic check_frame(input string tag, input int base,
                               input logic [63:0] l0, input logic [63:0] mid,
                               input logic [63:0] l16);
        logic [63:0] exp;
        logic [63:0] got;
        logic [63:0] gotf;
        for (int i = 0; i < 25; i++) begin
            exp  = (i == 0) ? l0 : (i < 16) ? mid : (i == 16) ? l16 : 64'd0;
            got  = (base + i < q_dout.size()) ? q_dout[base + i] : 64'hx;
            gotf = (base + i < q_first.size()) ? 64'(q_first[base + i]) : 64'hx;
            chk($sformatf("%s_lane%0d", tag, i), got, exp);
            chk($sformatf("%s_first%0d", tag, i), gotf, (i == 0) ? 64'd1 : 64'd0);
        end
    endtask

    task automatic clear_q();
        q_dout.delete();
        q_first.delete();
    endtask

    initial begin
        rst = 1'b1; pushin = 1'b0; lastin = 1'b0; din = 8'h00; stopout = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pushout", 64'(pushout), 64'd0);
        chk("rst_firstout", 64'(firstout), 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_stopin", 64'(stopin), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_stopin", 64'(stopin), 64'd0);
        @(posedge clk); #1;

        // 1: "abc"
        send_abc(); idle();
        wait_lanes("abc", 25);
        check_frame("abc", 0, 64'h0000_0000_0663_6261, 64'd0, 64'h8000_0000_0000_0000);
        clear_q();

        // 2: 135 bytes of AA, DSBYTE lands in the top byte with the final pad bit
        for (int i = 0; i < 135; i++) send_byte(8'hAA, (i == 134));
        idle();
        wait_lanes("aa135", 25);
        check_frame("aa135", 0, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA,
                    64'h86AA_AAAA_AAAA_AAAA);
        clear_q();

        // 3: 136 zero bytes fill the block exactly -> extra padding-only frame
        for (int i = 0; i < 136; i++) send_byte(8'h00, (i == 135));
        idle();
        wait_lanes("z136", 50);
        check_frame("z136_f1", 0, 64'd0, 64'd0, 64'd0);
        check_frame("z136_f2", 25, 64'h06, 64'd0, 64'h8000_0000_0000_0000);
        clear_q();

        // 4: stall 10 cycles while lane 3 is presented
        fork
            begin
                send_abc(); idle();
            end
            begin
                for (int k = 0; k < 500 && q_dout.size() != 3; k++) @(posedge clk);
                #1;
                stopout = 1'b1;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk($sformatf("stall_dout%0d", c), dout, 64'd0);
                    chk($sformatf("stall_push%0d", c), 64'(pushout), 64'd1);
                    chk($sformatf("stall_stopin%0d", c), 64'(stopin), 64'd1);
                end
                @(posedge clk); #1;
                stopout = 1'b0;
            end
        join
        wait_lanes("stall", 25);
        check_frame("stall", 0, 64'h0000_0000_0663_6261, 64'd0, 64'h8000_0000_0000_0000);
        clear_q();

        // 5: reset aborts an unfinished message
        for (int i = 0; i < 20; i++) send_byte(8'h11, 1'b0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_q();
        @(negedge clk);
        chk("abort_pushout", 64'(pushout), 64'd0);
        @(posedge clk); #1;
        send_abc(); idle();
        wait_lanes("abort", 25);
        check_frame("abort", 0, 64'h0000_0000_0663_6261, 64'd0, 64'h8000_0000_0000_0000);
        clear_q();

        // 6: two back-to-back "abc" with pushin held high
        send_abc();
        send_abc();
        idle();
        wait_lanes("b2b", 50);
        check_frame("b2b_f1", 0, 64'h0000_0000_0663_6261, 64'd0, 64'h8000_0000_0000_0000);
        check_frame("b2b_f2", 25, 64'h0000_0000_0663_6261, 64'd0, 64'h8000_0000_0000_0000);
        clear_q();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
